// File: rtl/fifo_stream_pkg.sv
// rtl/fifo_stream_pkg.sv - shared constants and buffer state encoding for fifo_stream_reader
package fifo_stream_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int PKT_LEN_DEF = 256;
  localparam int BUF_DEPTH   = 2;
  localparam int PKT_CNT_W   = 16;
  localparam int OCC_W       = $clog2(BUF_DEPTH + 1);

  typedef logic [OCC_W-1:0] buf_state_t;

  // Encoding equals the number of buffered words, so the state doubles as occ.
  localparam buf_state_t ST_EMPTY = 2'd0;
  localparam buf_state_t ST_ONE   = 2'd1;
  localparam buf_state_t ST_TWO   = 2'd2;

endpackage

// File: rtl/fifo_stream_skid.sv
// rtl/fifo_stream_skid.sv - 2-entry output buffer absorbing the FIFO read latency
module fifo_stream_skid
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              valid,
  output logic [OCC_W-1:0]  occ
);

  buf_state_t        state;
  logic [DATA_W-1:0] tail;

  assign valid = (state != ST_EMPTY);
  assign occ   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            head  <= push_data;
            state <= ST_ONE;
          end
        end
        ST_ONE: begin
          case ({push, pop})
            2'b10: begin
              tail  <= push_data;
              state <= ST_TWO;
            end
            2'b01: state <= ST_EMPTY;
            2'b11: head <= push_data;
            default: ;
          endcase
        end
        ST_TWO: begin
          // push without pop cannot occur here: the reader never over-issues.
          if (pop) begin
            head <= tail;
            if (push) tail <= push_data;
            else      state <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains a standard-mode sync FIFO into a valid/ready stream; FIFO_STREAM_READER_LAST_EN enables o_m_last
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PKT_LEN = PKT_LEN_DEF
) (
  input  logic              i_sys_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_fifo_dout,
  input  logic              i_fifo_empty,
  output logic              o_fifo_rd_en,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic              o_m_last
);

  logic             rd_pend;
  logic             pop;
  logic [OCC_W-1:0] occ;
  logic [OCC_W:0]   level;

  assign pop   = o_m_valid & i_m_ready;
  assign level = {1'b0, occ} + {{OCC_W{1'b0}}, rd_pend};

  // Words held plus in flight, less the word leaving now, must leave room for one more.
  assign o_fifo_rd_en = ~i_rst & ~i_fifo_empty &
                        (level <= ({{OCC_W{1'b0}}, pop} + {{OCC_W{1'b0}}, 1'b1}));

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) rd_pend <= 1'b0;
    else       rd_pend <= o_fifo_rd_en;
  end

  fifo_stream_skid #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk      (i_sys_clk),
    .rst      (i_rst),
    .push     (rd_pend),
    .push_data(i_fifo_dout),
    .pop      (pop),
    .head     (o_m_data),
    .valid    (o_m_valid),
    .occ      (occ)
  );

`ifdef FIFO_STREAM_READER_LAST_EN
  localparam logic [PKT_CNT_W-1:0] LAST_IDX = PKT_CNT_W'(PKT_LEN - 1);

  logic [PKT_CNT_W-1:0] pkt_cnt;

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      pkt_cnt <= '0;
    end else if (pop) begin
      if (pkt_cnt == LAST_IDX) pkt_cnt <= '0;
      else                     pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

  assign o_m_last = o_m_valid & (pkt_cnt == LAST_IDX);
`else
  assign o_m_last = 1'b0;
`endif

endmodule
